// File: rtl/io_bus_fabric.sv
// I/O bus fabric: decodes core I/O requests onto one-hot device selects with
// held strobes, waits for a per-device acknowledge, and aborts on timeout.
module io_bus_fabric #(
    parameter int unsigned N_DEV   = 5,
    parameter logic [10:0] TOP_ID  = 11'h7FF,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic [15:0]           io_addr,
    input  logic [DW-1:0]         io_wdata,
    input  logic                  io_read_req,
    input  logic                  io_write_req,
    output logic                  io_busy,
    output logic [DW-1:0]         io_rdata,
    output logic                  io_rdata_valid,
    output logic                  bus_error,
    input  logic                  err_clear,
    output logic [N_DEV-1:0]      dev_sel,
    output logic [3:0]            dev_offset,
    output logic                  dev_read,
    output logic                  dev_write,
    output logic [DW-1:0]         dev_wdata,
    input  logic [N_DEV*DW-1:0]   dev_rdata,
    input  logic [N_DEV-1:0]      dev_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [N_DEV-1:0] r_sel;
    logic [3:0]       r_offset;
    logic             r_read;
    logic             r_write;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    r_rdata;
    logic             r_rdata_valid;
    logic             r_bus_error;
    logic [15:0]      r_cnt;

    logic [10:0]      w_id;
    logic [10:0]      w_diff;
    logic             w_mapped;
    logic [N_DEV-1:0] w_dec;
    logic             w_ack;
    logic [DW-1:0]    w_slice;
    logic             w_expire;
    logic             w_timeout;
    logic             w_unused;

    assign w_id     = io_addr[14:4];
    assign w_diff   = TOP_ID - w_id;
    assign w_unused = io_addr[15];

    // Device k answers to TOP_ID-k; anything outside that window is unmapped.
    always_comb begin
        w_mapped = (w_id <= TOP_ID) && (32'(w_diff) < N_DEV);
        w_dec    = '0;
        for (int unsigned k = 0; k < N_DEV; k++) begin
            w_dec[k] = w_mapped && (32'(w_diff) == k);
        end
    end

    // Only the selected device's ack and read data are visible.
    always_comb begin
        w_ack   = 1'b0;
        w_slice = '0;
        for (int unsigned k = 0; k < N_DEV; k++) begin
            w_ack   = w_ack | (r_sel[k] & dev_ack[k]);
            w_slice = w_slice | ({DW{r_sel[k]}} & dev_rdata[k*DW +: DW]);
        end
    end

    assign w_expire  = (r_cnt == 16'(TIMEOUT - 1));
    assign w_timeout = (r_state == S_ACCESS) && !w_ack && w_expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_sel         <= '0;
            r_offset      <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_bus_error   <= 1'b0;
            r_cnt         <= '0;
        end else if (clk_en) begin
            r_rdata_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_read_req || io_write_req) begin
                        r_offset <= io_addr[3:0];
                        r_wdata  <= io_wdata;
                        if (w_mapped) begin
                            r_sel   <= w_dec;
                            r_write <= io_write_req;
                            r_read  <= !io_write_req;
                            r_state <= S_ACCESS;
                        end else begin
                            if (!io_write_req) begin
                                r_rdata       <= '1;
                                r_rdata_valid <= 1'b1;
                            end
                            r_state <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack is checked before expiry so a last-cycle ack still succeeds.
                    if (w_ack) begin
                        r_sel   <= '0;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_read) begin
                            r_rdata       <= w_slice;
                            r_rdata_valid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else if (w_expire) begin
                        r_sel   <= '0;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_read) begin
                            r_rdata       <= '1;
                            r_rdata_valid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end else if (err_clear) begin
                r_bus_error <= 1'b0;
            end
        end
    end

    assign io_busy        = (r_state == S_ACCESS);
    assign io_rdata       = r_rdata;
    assign io_rdata_valid = r_rdata_valid;
    assign bus_error      = r_bus_error;
    assign dev_sel        = r_sel;
    assign dev_offset     = r_offset;
    assign dev_read       = r_read;
    assign dev_write      = r_write;
    assign dev_wdata      = r_wdata;

endmodule
